// File: rtl/rmst_to_fifo_loader.sv
// rmst_to_fifo_loader
// Fetches a tile of param_iolen DW-bit words from external memory through an
// Avalon read master. Bursts are at most BLEN words long. Each XDW-bit master
// word is split into WCNT DW-bit words, which are pushed into the load FIFO in
// address order. Completion is reported with a one-cycle load_done pulse.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   load_start                one-cycle start request (honoured in IDLE only)
//   param_raddr, param_iolen  tile base byte address / length in DW words
//   load_done                 one-cycle completion pulse
//   rmst_*                    read-master command and show-ahead buffer
//                             interface (rmst_user_read_buffer pops the buffer)
//   load_data, load_fifo_push word and push strobe towards the load FIFO
//   load_fifo_full            FIFO cannot accept a push this cycle
module rmst_to_fifo_loader #(
  parameter int AW   = 12,
  parameter int CW   = 6,
  parameter int DW   = 32,
  parameter int XAW  = 32,
  parameter int XDW  = 128,
  parameter int WCNT = XDW / DW,
  parameter int BLEN = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_start,
  input  logic [XAW-1:0] param_raddr,
  input  logic [AW-1:0]  param_iolen,
  output logic           load_done,
  output logic           rmst_fixed_location,
  output logic [XAW-1:0] rmst_read_base,
  output logic [CW-1:0]  rmst_read_length,
  output logic           rmst_go,
  input  logic           rmst_done,
  input  logic [XDW-1:0] rmst_user_read_data,
  input  logic           rmst_user_data_available,
  output logic           rmst_user_read_buffer,
  output logic [DW-1:0]  load_data,
  output logic           load_fifo_push,
  input  logic           load_fifo_full
);

  localparam int WCW = $clog2(WCNT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WAIT_LOW,
    S_BUSY,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  iolen_q, iolen_d;
  logic [AW-1:0]  rd_len_q, rd_len_d;
  logic [XAW-1:0] rd_base_q, rd_base_d;
  // recv_cnt can overshoot iolen by up to WCNT-1 on the final beat.
  logic [AW:0]    recv_cnt_q, recv_cnt_d;
  logic [AW-1:0]  pushed_cnt_q, pushed_cnt_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic [XDW-1:0] shreg_q, shreg_d;

  logic [AW-1:0]  burst_words;
  logic [AW+1:0]  burst_bytes;
  logic           start_clear;
  logic           active;
  logic           push;
  logic           pop;

  always_comb begin
    burst_words = (rd_len_q > AW'(BLEN)) ? AW'(BLEN) : rd_len_q;
    burst_bytes = {burst_words, 2'b00};
  end

  assign active = (state_q != S_IDLE);

  assign push = active && (word_cnt_q != '0) && !load_fifo_full &&
                (pushed_cnt_q < iolen_q);

  // Refill when the shift register is empty, or when its last word leaves in
  // this very cycle so the stream has no bubble between beats.
  assign pop = active && rmst_user_data_available &&
               (recv_cnt_q < {1'b0, iolen_q}) &&
               ((word_cnt_q == '0) || ((word_cnt_q == WCW'(1)) && push));

  assign rmst_user_read_buffer = pop;
  assign load_fifo_push        = push;
  assign load_data             = shreg_q[DW-1:0];
  assign rmst_fixed_location   = 1'b0;

  // Command FSM
  always_comb begin
    state_d          = state_q;
    iolen_d          = iolen_q;
    rd_len_d         = rd_len_q;
    rd_base_d        = rd_base_q;
    start_clear      = 1'b0;
    rmst_go          = 1'b0;
    load_done        = 1'b0;
    rmst_read_base   = '0;
    rmst_read_length = '0;
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          iolen_d     = param_iolen;
          rd_len_d    = param_iolen;
          rd_base_d   = param_raddr;
          start_clear = 1'b1;
          state_d     = (param_iolen == '0) ? S_DRAIN : S_CMD;
        end
      end
      S_CMD: begin
        rmst_go          = 1'b1;
        rmst_read_base   = rd_base_q;
        rmst_read_length = burst_bytes[CW-1:0];
        rd_base_d        = rd_base_q + XAW'(burst_bytes);
        rd_len_d         = rd_len_q - burst_words;
        state_d          = S_WAIT_LOW;
      end
      // The master only drops rmst_done after it has taken the command.
      S_WAIT_LOW: begin
        if (!rmst_done) state_d = S_BUSY;
      end
      S_BUSY: begin
        if (rmst_done) state_d = (rd_len_q != '0) ? S_CMD : S_DRAIN;
      end
      S_DRAIN: begin
        if (pushed_cnt_q == iolen_q) state_d = S_DONE;
      end
      S_DONE: begin
        load_done = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Unpacker
  always_comb begin
    shreg_d      = shreg_q;
    word_cnt_d   = word_cnt_q;
    recv_cnt_d   = recv_cnt_q;
    pushed_cnt_d = pushed_cnt_q;
    if (start_clear) begin
      word_cnt_d   = '0;
      recv_cnt_d   = '0;
      pushed_cnt_d = '0;
    end else begin
      if (push) begin
        shreg_d      = shreg_q >> DW;
        word_cnt_d   = word_cnt_q - WCW'(1);
        pushed_cnt_d = pushed_cnt_q + AW'(1);
      end
      // A pop overrides the shift: the new beat replaces the spent word.
      if (pop) begin
        shreg_d    = rmst_user_read_data;
        word_cnt_d = WCW'(WCNT);
        recv_cnt_d = recv_cnt_q + (AW+1)'(WCNT);
      end
      // Words of the final beat beyond the tile length are dropped.
      if (push && (pushed_cnt_d == iolen_q)) word_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      iolen_q      <= '0;
      rd_len_q     <= '0;
      rd_base_q    <= '0;
      recv_cnt_q   <= '0;
      pushed_cnt_q <= '0;
      word_cnt_q   <= '0;
      shreg_q      <= '0;
    end else begin
      state_q      <= state_d;
      iolen_q      <= iolen_d;
      rd_len_q     <= rd_len_d;
      rd_base_q    <= rd_base_d;
      recv_cnt_q   <= recv_cnt_d;
      pushed_cnt_q <= pushed_cnt_d;
      word_cnt_q   <= word_cnt_d;
      shreg_q      <= shreg_d;
    end
  end

endmodule

// File: tb/tb_rmst_to_fifo_loader.sv
// Testbench for rmst_to_fifo_loader: a behavioural read master backed by a
// word memory, a scoreboard of expected bursts and pushed words derived from
// the tile parameters, and directed plus randomized loads.
module tb_rmst_to_fifo_loader;

  localparam int AW  = 12;
  localparam int CW  = 6;
  localparam int DW  = 32;
  localparam int XAW = 32;
  localparam int XDW = 128;

  logic           clk = 1'b0;
  logic           rst;
  logic           load_start;
  logic [XAW-1:0] param_raddr;
  logic [AW-1:0]  param_iolen;
  logic           load_done;
  logic           rmst_fixed_location;
  logic [XAW-1:0] rmst_read_base;
  logic [CW-1:0]  rmst_read_length;
  logic           rmst_go;
  logic           rmst_done;
  logic [XDW-1:0] rmst_user_read_data;
  logic           rmst_user_data_available;
  logic           rmst_user_read_buffer;
  logic [DW-1:0]  load_data;
  logic           load_fifo_push;
  logic           load_fifo_full;

  always #5 clk = ~clk;

  rmst_to_fifo_loader dut (
    .clk                      (clk),
    .rst                      (rst),
    .load_start               (load_start),
    .param_raddr              (param_raddr),
    .param_iolen              (param_iolen),
    .load_done                (load_done),
    .rmst_fixed_location      (rmst_fixed_location),
    .rmst_read_base           (rmst_read_base),
    .rmst_read_length         (rmst_read_length),
    .rmst_go                  (rmst_go),
    .rmst_done                (rmst_done),
    .rmst_user_read_data      (rmst_user_read_data),
    .rmst_user_data_available (rmst_user_data_available),
    .rmst_user_read_buffer    (rmst_user_read_buffer),
    .load_data                (load_data),
    .load_fifo_push           (load_fifo_push),
    .load_fifo_full           (load_fifo_full)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // External memory (word addressed) and read-master model state
  logic [31:0]  mem [0:1023];
  logic [127:0] mbuf [$];
  int  m_pending = 0;
  int  m_wi      = 0;
  bit  got_go    = 0;
  int  go_base   = 0;
  int  go_len    = 0;
  bit  m_fast    = 0;

  // Scoreboard
  int          exp_base [$];
  int          exp_len  [$];
  logic [31:0] exp_words [$];
  int go_idx, push_idx, popped, done_cnt, done_cyc, first_push, last_push, go_first_cyc;
  int full_trig, full_left, full_drop_cyc;
  bit full_rand, dir_full, resume_pending;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: observe outputs at the falling edge, update inputs 1
  // time unit after the rising edge.
  task automatic cycle();
    logic [127:0] b;
    @(negedge clk);
    if (rmst_go) begin
      if (go_idx < exp_base.size()) begin
        chk("burst_base", rmst_read_base, exp_base[go_idx]);
        chk("burst_len", rmst_read_length, exp_len[go_idx]);
      end else begin
        chk("go_count", go_idx + 1, exp_base.size());
      end
      if (go_idx == 0) go_first_cyc = cyc;
      go_idx++;
      got_go  = 1;
      go_base = int'(rmst_read_base);
      go_len  = int'(rmst_read_length);
    end
    if (load_fifo_push) begin
      if (push_idx < exp_words.size()) chk("push_data", load_data, exp_words[push_idx]);
      else chk("push_count", push_idx + 1, exp_words.size());
      if (push_idx == 0) first_push = cyc;
      last_push = cyc;
      if (resume_pending) begin
        chk("resume_cycle", cyc, full_drop_cyc);
        resume_pending = 0;
      end
      push_idx++;
    end
    if (load_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (rmst_user_read_buffer && mbuf.size() != 0) begin
      void'(mbuf.pop_front());
      popped++;
    end
    @(posedge clk);
    #1;
    cyc++;
    load_start = 1'b0;
    // Read master: drop done on a command, then fill the buffer beat by beat
    if (got_go) begin
      got_go    = 0;
      m_pending = (go_len + 15) / 16;
      m_wi      = go_base >> 2;
      rmst_done = 1'b0;
    end else if (m_pending > 0) begin
      if (m_fast || $urandom_range(3) != 0) begin
        for (int j = 0; j < 4; j++) b[32*j +: 32] = mem[(m_wi + j) & 1023];
        mbuf.push_back(b);
        m_wi += 4;
        m_pending--;
      end
    end else begin
      rmst_done = 1'b1;
    end
    rmst_user_data_available = (mbuf.size() != 0);
    rmst_user_read_data      = (mbuf.size() != 0) ? mbuf[0] : {4{$urandom}};
    // FIFO back-pressure
    if (full_left > 0 && push_idx == full_trig) begin
      load_fifo_full = 1'b1;
      dir_full       = 1;
      full_left--;
    end else begin
      if (load_fifo_full && dir_full) begin
        dir_full       = 0;
        resume_pending = 1;
        full_drop_cyc  = cyc;
      end
      load_fifo_full = full_rand ? ($urandom_range(3) == 0) : 1'b0;
    end
  endtask

  task automatic run_load(input int raddr, input int iolen, input int trig, input bit rfull,
                          input bit fast, input bit consec, input bit abort);
    int rem, a, w, t0;
    exp_base.delete();
    exp_len.delete();
    exp_words.delete();
    rem = iolen;
    a   = raddr;
    while (rem > 0) begin
      w = (rem > 8) ? 8 : rem;
      exp_base.push_back(a);
      exp_len.push_back(w * 4);
      a   += w * 4;
      rem -= w;
    end
    for (int i = 0; i < iolen; i++) exp_words.push_back(mem[((raddr >> 2) + i) & 1023]);
    go_idx = 0; push_idx = 0; popped = 0; done_cnt = 0; done_cyc = -1;
    first_push = -1; last_push = -1; go_first_cyc = -1;
    full_trig = trig; full_left = (trig >= 0) ? 5 : 0; full_rand = rfull; m_fast = fast;
    dir_full = 0; resume_pending = 0;
    param_raddr = XAW'(raddr);
    param_iolen = AW'(iolen);
    load_start  = 1'b1;
    t0 = cyc;
    if (abort) begin
      for (int n = 0; n < 200 && go_idx == 0; n++) cycle();
      chk("abort_go_seen", go_idx, 1);
      for (int n = 0; n < 3; n++) cycle();
      return;
    end
    for (int n = 0; n < 2000 && done_cnt == 0; n++) cycle();
    chk("done_seen", done_cnt, 1);
    for (int n = 0; n < 4; n++) cycle();
    chk("done_count", done_cnt, 1);
    chk("go_count", go_idx, exp_base.size());
    chk("push_count", push_idx, iolen);
    chk("beats_popped", popped, (iolen + 3) / 4);
    chk("buffer_left", mbuf.size(), 0);
    if (iolen == 0) begin
      chk("done_latency", done_cyc, t0 + 2);
    end else begin
      chk("done_latency", done_cyc, last_push + 2);
      chk("go_latency", go_first_cyc, t0 + 1);
    end
    if (consec) chk("push_consecutive", last_push - first_push, iolen - 1);
    if (trig >= 0) chk("resume_seen", resume_pending, 0);
    full_rand      = 0;
    load_fifo_full = 1'b0;
    $display("load raddr=0x%0h iolen=%0d bursts=%0d pushes=%0d done_cyc=%0d",
             raddr, iolen, go_idx, push_idx, done_cyc);
  endtask

  initial begin
    rst                      = 1'b1;
    load_start               = 1'b0;
    param_raddr              = '0;
    param_iolen              = '0;
    rmst_done                = 1'b1;
    rmst_user_read_data      = '0;
    rmst_user_data_available = 1'b0;
    load_fifo_full           = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_go", rmst_go, 0);
    chk("rst_done", load_done, 0);
    chk("rst_base", rmst_read_base, 0);
    chk("rst_length", rmst_read_length, 0);
    chk("rst_pop", rmst_user_read_buffer, 0);
    chk("rst_push", load_fifo_push, 0);
    chk("rst_data", load_data, 0);
    chk("rst_fixed", rmst_fixed_location, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_load('h100, 8, -1, 0, 1, 1, 0);
    run_load('h000, 20, -1, 0, 0, 0, 0);
    run_load('h180, 8, 2, 0, 1, 0, 0);
    run_load('h240, 6, -1, 0, 0, 0, 0);
    run_load('h040, 0, -1, 0, 0, 0, 0);

    // Reset in the middle of a 16-word load
    run_load('h200, 16, -1, 0, 0, 0, 1);
    rst = 1'b1;
    cycle();
    mbuf.delete();
    m_pending                = 0;
    got_go                   = 0;
    rmst_done                = 1'b1;
    rmst_user_data_available = 1'b0;
    @(negedge clk);
    chk("mid_rst_go", rmst_go, 0);
    chk("mid_rst_done", load_done, 0);
    chk("mid_rst_base", rmst_read_base, 0);
    chk("mid_rst_length", rmst_read_length, 0);
    chk("mid_rst_pop", rmst_user_read_buffer, 0);
    chk("mid_rst_push", load_fifo_push, 0);
    chk("mid_rst_data", load_data, 0);
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    run_load('h300, 4, -1, 0, 0, 0, 0);

    for (int r = 0; r < 3; r++)
      run_load(int'($urandom_range(0, 'hB0)) << 4, int'($urandom_range(1, 40)), -1, 1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
